// File: rtl/cell_truth_checker.sv
// Exhaustive truth-table sequencer for single-output standard cells: drives every
// input vector, waits a settle window, samples the cell and scores it against EXP_TABLE.
module cell_truth_checker #(
    parameter int                       N_IN      = 3,
    parameter int                       SETTLE    = 2,
    parameter logic [(1 << N_IN) - 1:0] EXP_TABLE = 8'h1F
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            cell_out,
    output logic [N_IN-1:0] cell_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            res_valid,
    output logic [N_IN-1:0] res_vec,
    output logic            res_bit,
    output logic            res_ok
);

    localparam int                WAIT_W     = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [WAIT_W-1:0] SETTLE_CNT = WAIT_W'(SETTLE);
    localparam logic [N_IN:0]     LAST_VEC   = {1'b0, {N_IN{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [WAIT_W-1:0] wait_r, wait_s;
    logic [N_IN:0]     vec_r, vec_s;
    logic [N_IN:0]     err_r, err_s;
    logic              ffv_r, ffv_s;
    logic [N_IN-1:0]   ffvec_r, ffvec_s;
    logic              res_valid_r, res_valid_s;
    logic [N_IN-1:0]   res_vec_r, res_vec_s;
    logic              res_bit_r, res_bit_s;
    logic              res_ok_r, res_ok_s;
    logic              mismatch_s;

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wait_r      <= {WAIT_W{1'b0}};
            vec_r       <= {(N_IN + 1){1'b0}};
            err_r       <= {(N_IN + 1){1'b0}};
            ffv_r       <= 1'b0;
            ffvec_r     <= {N_IN{1'b0}};
            res_valid_r <= 1'b0;
            res_vec_r   <= {N_IN{1'b0}};
            res_bit_r   <= 1'b0;
            res_ok_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            wait_r      <= wait_s;
            vec_r       <= vec_s;
            err_r       <= err_s;
            ffv_r       <= ffv_s;
            ffvec_r     <= ffvec_s;
            res_valid_r <= res_valid_s;
            res_vec_r   <= res_vec_s;
            res_bit_r   <= res_bit_s;
            res_ok_r    <= res_ok_s;
        end
    end

    // Next-state, vector sequencing and scoring
    always_comb begin
        state_s     = state_r;
        wait_s      = wait_r;
        vec_s       = vec_r;
        err_s       = err_r;
        ffv_s       = ffv_r;
        ffvec_s     = ffvec_r;
        res_valid_s = 1'b0;
        res_vec_s   = res_vec_r;
        res_bit_s   = res_bit_r;
        res_ok_s    = res_ok_r;
        mismatch_s  = (cell_out != EXP_TABLE[vec_r[N_IN-1:0]]);

        // abort wins over start and also swallows a sample on the same edge
        if (abort) begin
            state_s = ST_IDLE;
            wait_s  = {WAIT_W{1'b0}};
            vec_s   = {(N_IN + 1){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_s = ST_DRIVE;
                        wait_s  = {WAIT_W{1'b0}};
                        vec_s   = {(N_IN + 1){1'b0}};
                        err_s   = {(N_IN + 1){1'b0}};
                        ffv_s   = 1'b0;
                        ffvec_s = {N_IN{1'b0}};
                    end else begin
                        vec_s = {(N_IN + 1){1'b0}};
                    end
                end
                ST_DRIVE: begin
                    if (wait_r == SETTLE_CNT) begin
                        res_valid_s = 1'b1;
                        res_vec_s   = vec_r[N_IN-1:0];
                        res_bit_s   = cell_out;
                        res_ok_s    = !mismatch_s;
                        if (mismatch_s) begin
                            err_s = err_r + (N_IN + 1)'(1);
                            if (!ffv_r) begin
                                ffv_s   = 1'b1;
                                ffvec_s = vec_r[N_IN-1:0];
                            end else begin
                                ffvec_s = ffvec_r;
                            end
                        end else begin
                            err_s = err_r;
                        end
                        wait_s = {WAIT_W{1'b0}};
                        if (vec_r == LAST_VEC) begin
                            state_s = ST_DONE;
                            vec_s   = {(N_IN + 1){1'b0}};
                        end else begin
                            vec_s = vec_r + (N_IN + 1)'(1);
                        end
                    end else begin
                        wait_s = wait_r + WAIT_W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    wait_s  = {WAIT_W{1'b0}};
                    vec_s   = {(N_IN + 1){1'b0}};
                end
            endcase
        end
    end

    assign cell_in          = vec_r[N_IN-1:0];
    assign busy             = (state_r == ST_DRIVE);
    assign done             = (state_r == ST_DONE);
    assign pass             = done && (err_r == {(N_IN + 1){1'b0}});
    assign err_count        = err_r;
    assign first_fail_valid = ffv_r;
    assign first_fail_vec   = ffvec_r;
    assign res_valid        = res_valid_r;
    assign res_vec          = res_vec_r;
    assign res_bit          = res_bit_r;
    assign res_ok           = res_ok_r;

endmodule

// File: doc/cell_truth_checker.md
# cell_truth_checker

Self-checking exhaustive truth-table sequencer for N-input, single-output standard cells (OAI/AOI/NAND/NOR families). It replaces the hand-written, print-only per-cell benches with one synthesizable block. The block drives every input vector to the cell under test, waits a settle window, samples the output, and compares it against a parameterised expected table. It sits beside the cell under test in each cell-level bench and is also usable as an on-chip BIST wrapper.

## Interface
- N_IN, 3: number of cell inputs; 1..8.
- SETTLE, 2: cycles each vector is held before its output is sampled; at least 1.
- EXP_TABLE, 8'h1F: 2^N_IN bits; bit i is the expected output for input vector i. The default is OAI21, ZN = ~(A & (B1 | B2)), with vector bits {A,B1,B2}.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- abort  in  1  stops a run in progress and returns to IDLE.
- cell_out  in  1  output of the cell under test.
- cell_in  out  N_IN  input vector to the cell; bit N_IN-1 is the first pin (A).
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE until the next start, abort or reset.
- pass  out  1  equals done AND (err_count == 0).
- err_count  out  N_IN+1  number of mismatching vectors in the current or last run.
- first_fail_valid  out  1  at least one mismatch has occurred this run.
- first_fail_vec  out  N_IN  vector index of the first mismatch.
- res_valid  out  1  one-cycle strobe per sampled vector.
- res_vec  out  N_IN  vector index for this strobe.
- res_bit  out  1  sampled cell_out value for this strobe.
- res_ok  out  1  res_bit equals EXP_TABLE[res_vec].

## Operation
- The FSM has three states: IDLE, DRIVE and DONE. A wait counter (width clog2(SETTLE+1)) and a vector counter (width N_IN+1) run inside DRIVE.
- IDLE or DONE with start=1 (and abort=0): go to DRIVE. On that edge, set cell_in=0 and wait=0, clear err_count, first_fail_valid and first_fail_vec, and deassert done.
- DRIVE: wait increments every cycle. When wait==SETTLE, the edge does all of the following:
  - samples cell_out;
  - registers res_* for vector v;
  - increments err_count on a mismatch, and latches first_fail_vec=v if first_fail_valid=0;
  - if v==2^N_IN-1, goes to DONE; otherwise sets cell_in=v+1 and wait=0.
- DONE: cell_in returns to 0 and done=1. Results are held until the next start.
- abort=1 in any state: go to IDLE on that edge. cell_in becomes 0, busy=0 and done=0. err_count and first_fail_* keep their values. A res_valid from that same edge is suppressed.
- abort and start high together: abort wins.
- start while in DRIVE: ignored. It does not restart the run and has no other effect.
- err_count cannot overflow, because its maximum value 2^N_IN fits in N_IN+1 bits.

## Timing
- Reset values: state IDLE, cell_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, res_valid=0, res_vec=0, res_bit=0, res_ok=0.
- Reset asserted mid-run forces all of the above values immediately, without waiting for clk. No result strobe follows.
- busy rises on the edge that accepts start. It falls on the edge that enters DONE, and done rises on that same edge.
- Each vector is held on cell_in for exactly SETTLE+1 cycles. A full run takes 2^N_IN × (SETTLE+1) cycles from start acceptance to done.
- res_valid for vector v is high for the one cycle after its sample edge, which is the first cycle of vector v+1. For the last vector it is high in the first DONE cycle.
- err_count and first_fail_* update on the same edge as the matching res_valid, so they are final when done rises.
- pass is combinational from registered state and has no additional latency.

## Test plan
- Default parameters with a correct OAI21 model: 24 busy cycles, then done=1, pass=1, err_count=0. Eight res_valid strobes with res_vec 0..7 and res_bit 1,1,1,1,1,0,0,0.
- The same setup with cell_out stuck at 1: err_count=3, first_fail_valid=1, first_fail_vec=5, pass=0, and res_ok=0 on vectors 5, 6 and 7.
- start pulsed again at vector 3 of a run: the sequence continues undisturbed and the totals match a run without the extra pulse. A start pulse in DONE begins a new run with err_count cleared.
- abort asserted while vector 4 is being driven: IDLE on the next edge, cell_in=0, busy=0, done=0, no res_valid. err_count keeps its pre-abort value.
- rst_n pulled low mid-run, between clock edges: all outputs at their reset values before the next clk edge. A subsequent start runs a full pass cleanly.
- N_IN=1, SETTLE=1, EXP_TABLE=2'b01 with an inverter: 4 busy cycles, res_bit 1 then 0, pass=1. N_IN=4 NAND4 with EXP_TABLE=16'h7FFF and SETTLE=3: 64 busy cycles, pass=1.
